// File: rtl/multimem_write_scheduler.sv
// Port-A write sequencer for the double-buffered multimem frame buffer.
// Streams or clear-fills the back bank, then swaps banks on a display frame boundary.
module multimem_write_scheduler #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int FRAME_BYTES = 2048
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] stream_data,
    input  logic                  stream_valid,
    output logic                  stream_ready,
    input  logic                  frame_start,
    input  logic                  clear_req,
    input  logic [DATA_WIDTH-1:0] clear_value,
    input  logic                  frame_boundary,
    output logic [ADDR_WIDTH-1:0] ram_a_address,
    output logic [DATA_WIDTH-1:0] ram_a_data_in,
    output logic                  ram_a_clk_enable,
    output logic                  ram_a_wr,
    output logic                  display_bank,
    output logic                  busy_clear,
    output logic                  frame_done,
    output logic [1:0]            dbg_state
);
    localparam int OFF_W = ADDR_WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_STREAM    = 2'd1,
        S_CLEAR     = 2'd2,
        S_WAIT_SWAP = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [OFF_W-1:0]      offset_q, offset_d;
    logic                  bank_q, bank_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  last_off;

    // Handshake: a byte transfers on a rising edge where stream_valid && stream_ready;
    // stream_ready depends on state only, never on stream_valid.
    assign stream_ready = (state_q == S_STREAM);
    assign last_off     = (offset_q == OFF_W'(FRAME_BYTES - 1));

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        bank_d   = bank_q;
        fill_d   = fill_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The offset-0 clear write is issued on the request edge so busy_clear
                // rises the very next cycle and the fill spans exactly FRAME_BYTES cycles.
                if (clear_req) begin
                    fill_d   = clear_value;
                    we_d     = 1'b1;
                    busy_d   = 1'b1;
                    addr_d   = {~bank_q, {OFF_W{1'b0}}};
                    data_d   = clear_value;
                    offset_d = OFF_W'(1);
                    state_d  = S_CLEAR;
                end else if (frame_start) begin
                    offset_d = '0;
                    state_d  = S_STREAM;
                end
            end
            S_STREAM: begin
                if (stream_valid) begin
                    we_d     = 1'b1;
                    addr_d   = {~bank_q, offset_q};
                    data_d   = stream_data;
                    offset_d = offset_q + OFF_W'(1);
                    if (last_off) begin
                        done_d  = 1'b1;
                        state_d = S_WAIT_SWAP;
                    end
                end
                if (frame_start) begin
                    offset_d = '0;
                end
            end
            S_CLEAR: begin
                we_d     = 1'b1;
                busy_d   = 1'b1;
                addr_d   = {~bank_q, offset_q};
                data_d   = fill_q;
                offset_d = offset_q + OFF_W'(1);
                if (last_off) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_SWAP: begin
                if (frame_boundary) begin
                    bank_d  = ~bank_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            offset_q <= '0;
            bank_q   <= 1'b0;
            fill_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            bank_q   <= bank_d;
            fill_q   <= fill_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign ram_a_address    = addr_q;
    assign ram_a_data_in    = data_q;
    assign ram_a_clk_enable = we_q;
    assign ram_a_wr         = we_q;
    assign display_bank     = bank_q;
    assign busy_clear       = busy_q;
    assign frame_done       = done_q;
    assign dbg_state        = state_q;
endmodule
